// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight register writers from EX to WB and
// produces per-source forwarding selects plus a load-use stall for the ID instruction.
module fwd_scoreboard #(
  parameter int DEPTH       = 3,
  parameter int NUM_SRC     = 2,
  parameter int REG_IDX_W   = 5,
  parameter int FLUSH_SLOTS = 2,
  parameter int LAT_W       = $clog2(DEPTH),
  parameter int SEL_W       = $clog2(DEPTH+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall_n,
  input  logic                           flush,
  input  logic                           id_valid,
  input  logic [NUM_SRC*REG_IDX_W-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]             id_rs_used,
  input  logic [REG_IDX_W-1:0]           id_rd,
  input  logic                           id_wen,
  input  logic [LAT_W-1:0]               id_lat,
  output logic [NUM_SRC*SEL_W-1:0]       fwd_sel,
  output logic                           hazard_stall,
  output logic [DEPTH-1:0]               slot_valid,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    flush_cnt
);

  // Handshake: there is no valid/ready pair here; stall_n is a global advance enable,
  // and hazard_stall is a same-cycle request consumed by the IF/ID hold and EX bubble.

  logic [DEPTH-1:0]     r_valid;
  logic [REG_IDX_W-1:0] r_rd  [DEPTH];
  logic [LAT_W-1:0]     r_lat [DEPTH];
  logic [31:0]          r_stall_cnt;
  logic [31:0]          r_flush_cnt;

  logic [DEPTH-1:0]     w_slot_rdy;
  logic [NUM_SRC-1:0]   w_src_wait;
  logic [LAT_W-1:0]     w_lat_clamped;
  logic                 w_issue;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_rdy[i] = (LAT_W'(i) >= r_lat[i]);
    end
  end

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    fwd_sel    = '0;
    w_src_wait = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (id_rs_used[s] && r_valid[i] && (r_rd[i] != '0) &&
            (r_rd[i] == id_rs[s*REG_IDX_W +: REG_IDX_W])) begin
          fwd_sel[s*SEL_W +: SEL_W] = w_slot_rdy[i] ? SEL_W'(i+1) : '0;
          w_src_wait[s]             = !w_slot_rdy[i];
        end
      end
    end
  end

  assign hazard_stall  = (|w_src_wait) && id_valid && !flush;
  assign w_issue       = id_valid && id_wen && !hazard_stall && !flush;
  assign w_lat_clamped = (int'(id_lat) >= DEPTH) ? LAT_W'(DEPTH-1) : id_lat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]  <= '0;
        r_lat[i] <= '0;
      end
    end else if (stall_n) begin
      r_valid[0] <= w_issue;
      r_rd[0]    <= id_rd;
      r_lat[0]   <= w_lat_clamped;
      // A flush kills the wrong-path entries in the youngest slots as they shift.
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= (flush && (i < FLUSH_SLOTS)) ? 1'b0 : r_valid[i-1];
        r_rd[i]    <= r_rd[i-1];
        r_lat[i]   <= r_lat[i-1];
      end
      if (hazard_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign slot_valid = r_valid;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the in-flight writers.
module tb_fwd_scoreboard;
  localparam int DEPTH = 3;
  localparam int NS    = 2;
  localparam int RW    = 5;
  localparam int FS    = 2;
  localparam int LW    = $clog2(DEPTH);
  localparam int SW    = $clog2(DEPTH+1);

  logic              clk;
  logic              rst;
  logic              stall_n;
  logic              flush;
  logic              id_valid;
  logic [NS*RW-1:0]  id_rs;
  logic [NS-1:0]     id_rs_used;
  logic [RW-1:0]     id_rd;
  logic              id_wen;
  logic [LW-1:0]     id_lat;
  logic [NS*SW-1:0]  fwd_sel;
  logic              hazard_stall;
  logic [DEPTH-1:0]  slot_valid;
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;

  fwd_scoreboard #(
    .DEPTH(DEPTH), .NUM_SRC(NS), .REG_IDX_W(RW), .FLUSH_SLOTS(FS), .LAT_W(LW), .SEL_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .stall_n(stall_n), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_wen(id_wen), .id_lat(id_lat),
    .fwd_sel(fwd_sel), .hazard_stall(hazard_stall), .slot_valid(slot_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  typedef struct { bit v; int rd; int lat; } ent_t;
  ent_t   sb[$];            // sb[0] is the writer currently in EX
  longint e_stall_cnt;
  longint e_flush_cnt;
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     chk_en   = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int rs_of(input int s);
    return int'(id_rs[s*RW +: RW]);
  endfunction

  // Index of the youngest in-flight writer of source s, or -1.
  function automatic int model_pick(input int s);
    if (!id_rs_used[s] || rs_of(s) == 0) return -1;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].v && sb[i].rd == rs_of(s)) return i;
    return -1;
  endfunction

  function automatic int model_sel(input int s);
    int k;
    k = model_pick(s);
    if (k >= 0 && k >= sb[k].lat) return k + 1;
    return 0;
  endfunction

  function automatic bit model_stall();
    bit w;
    int k;
    w = 1'b0;
    for (int s = 0; s < NS; s++) begin
      k = model_pick(s);
      if (k >= 0 && k < sb[k].lat) w = 1'b1;
    end
    return w && id_valid && !flush;
  endfunction

  function automatic int model_slot_valid();
    int m;
    m = 0;
    for (int i = 0; i < sb.size(); i++) if (sb[i].v) m |= (1 << i);
    return m;
  endfunction

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_step();
    ent_t n;
    bit   st;
    if (!rst) begin
      sb.delete();
      for (int i = 0; i < DEPTH; i++) sb.push_back('{v: 1'b0, rd: 0, lat: 0});
      e_stall_cnt = 0;
      e_flush_cnt = 0;
    end else if (stall_n && sb.size() == DEPTH) begin
      st    = model_stall();
      n.v   = id_valid && id_wen && !st && !flush;
      n.rd  = int'(id_rd);
      n.lat = (int'(id_lat) > DEPTH-1) ? DEPTH-1 : int'(id_lat);
      if (st && e_stall_cnt < 64'hFFFF_FFFF) e_stall_cnt++;
      if (flush && e_flush_cnt < 64'hFFFF_FFFF) e_flush_cnt++;
      sb.push_front(n);
      void'(sb.pop_back());
      if (flush) for (int i = 0; i < FS; i++) sb[i].v = 1'b0;
    end
  endtask

  // driver tasks
  task automatic next();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_id(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                        input int rd, input bit wen, input int lat);
    id_valid        = v;
    id_rs[0 +: RW]  = RW'(rs0);
    id_rs[RW +: RW] = RW'(rs1);
    id_rs_used      = used;
    id_rd           = RW'(rd);
    id_wen          = wen;
    id_lat          = LW'(lat);
  endtask

  task automatic do_reset();
    rst = 1'b0; stall_n = 1'b1; flush = 1'b0;
    set_id(0, 0, 0, 2'b00, 0, 0, 0);
    next();
    rst = 1'b1;
  endtask

  function automatic int got_sel(input int s);
    return int'(fwd_sel[s*SW +: SW]);
  endfunction

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int s = 0; s < NS; s++) chk($sformatf("model_fwd_sel%0d", s), got_sel(s), model_sel(s));
        chk("model_hazard_stall", hazard_stall, model_stall());
        chk("model_slot_valid", slot_valid, model_slot_valid());
        chk("model_stall_cnt", stall_cnt, e_stall_cnt);
        chk("model_flush_cnt", flush_cnt, e_flush_cnt);
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b0; stall_n = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 2'b00, 0, 0, 0);
    next();
    rst = 1'b1; stall_n = 1'b1; chk_en = 1'b1;
    #2;
    chk("reset_slot_valid", slot_valid, 0);
    chk("reset_hazard", hazard_stall, 0);
    chk("reset_fwd_sel", fwd_sel, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);

    // ALU chain
    set_id(1, 0, 0, 2'b00, 5, 1, 0); next();
    set_id(1, 5, 0, 2'b01, 0, 0, 0); #2;
    chk("alu_fwd_slot0", got_sel(0), 1);
    chk("alu_no_stall", hazard_stall, 0);
    next(); #2;
    chk("alu_fwd_slot1", got_sel(0), 2);

    // load-use
    do_reset();
    set_id(1, 0, 0, 2'b00, 6, 1, 1); next();
    set_id(1, 0, 6, 2'b10, 0, 0, 0); #2;
    chk("lu_stall", hazard_stall, 1);
    chk("lu_fwd_during_stall", got_sel(1), 0);
    next(); #2;
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_slot_valid", slot_valid, 3'b010);
    chk("lu_fwd_after", got_sel(1), 2);
    chk("lu_stall_released", hazard_stall, 0);

    // youngest writer wins
    do_reset();
    set_id(1, 0, 0, 2'b00, 7, 1, 0); next(); next();
    set_id(1, 7, 0, 2'b01, 0, 0, 0); #2;
    chk("youngest_fwd", got_sel(0), 1);

    // x0 and unused operands never match
    do_reset();
    set_id(1, 0, 0, 2'b00, 0, 1, 0); next();
    set_id(1, 0, 0, 2'b00, 9, 1, 1); next();
    set_id(1, 0, 9, 2'b01, 0, 0, 0); #2;
    chk("filter_fwd", fwd_sel, 0);
    chk("filter_no_stall", hazard_stall, 0);

    // flush beats a pending load-use stall
    do_reset();
    set_id(1, 0, 0, 2'b00, 3, 1, 0); next();
    set_id(1, 0, 0, 2'b00, 4, 1, 1); next();
    set_id(1, 4, 0, 2'b01, 0, 0, 0); #2;
    chk("flush_pre_slots", slot_valid, 3'b011);
    chk("flush_pre_stall", hazard_stall, 1);
    flush = 1'b1; #1;
    chk("flush_kills_stall", hazard_stall, 0);
    next(); flush = 1'b0; #2;
    chk("flush_slots", slot_valid, 3'b100);
    chk("flush_cnt", flush_cnt, 1);
    chk("flush_stall_cnt", stall_cnt, 0);

    // latency beyond the last slot is clamped to DEPTH-1
    set_id(1, 0, 0, 2'b00, 8, 1, 3); next();
    set_id(1, 8, 0, 2'b01, 0, 0, 0); #2;
    chk("clamp_stall_slot0", hazard_stall, 1);
    next(); #2;
    chk("clamp_stall_slot1", hazard_stall, 1);
    next(); #2;
    chk("clamp_fwd_slot2", got_sel(0), 3);
    chk("clamp_no_stall", hazard_stall, 0);
    chk("clamp_stall_cnt", stall_cnt, 2);

    // freeze: state and counters hold, outputs still track ID
    set_id(1, 0, 0, 2'b00, 5, 1, 1); next();
    set_id(1, 5, 0, 2'b01, 0, 0, 0);
    stall_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      flush = (k == 2);
      #2;
      chk($sformatf("freeze_hazard_%0d", k), hazard_stall, (k != 2));
      next();
    end
    flush = 1'b0; #2;
    chk("freeze_slots", slot_valid, 3'b001);
    chk("freeze_stall_cnt", stall_cnt, 2);
    chk("freeze_flush_cnt", flush_cnt, 1);

    // reset while frozen
    rst = 1'b0; next(); rst = 1'b1; #2;
    chk("frz_rst_slots", slot_valid, 0);
    chk("frz_rst_stall_cnt", stall_cnt, 0);
    chk("frz_rst_flush_cnt", flush_cnt, 0);
    chk("frz_rst_hazard", hazard_stall, 0);
    chk("frz_rst_fwd", fwd_sel, 0);
    stall_n = 1'b1;

    // random traffic on a small register set to force frequent hits
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) != 0);
      stall_n = ($urandom_range(0, 99) >= 15);
      flush   = ($urandom_range(0, 99) < 8);
      set_id($urandom_range(0, 99) < 85, $urandom_range(0, 4), $urandom_range(0, 4),
             2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 1),
             $urandom_range(0, 3));
      next();
    end

    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised hazard and forwarding unit for the pipelined RV32I core. It keeps a shift-register scoreboard of in-flight register writers from EX through the last pre-commit stage. Each cycle it produces a per-source forwarding select and a load-use stall request for the instruction in ID. It generalises fixed two-source EX/MEM forwarding to DEPTH producer stages, NUM_SRC operands and per-instruction result latency. It adds flush-depth control and saturating performance counters.

## Interface
- DEPTH, 3, number of scoreboard slots (slot 0 = EX, slot DEPTH-1 = WB); legal range 2..8
- NUM_SRC, 2, number of source operands checked per ID instruction
- REG_IDX_W, 5, register index width
- FLUSH_SLOTS, 2, number of youngest slots invalid after a flush; legal range 1..DEPTH-1
- LAT_W, $clog2(DEPTH), width of latency field
- SEL_W, $clog2(DEPTH+1), width of each forwarding select
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-low; one clock, one reset
- stall_n  in  1  global advance; low freezes all state (memory or muldiv stall)
- flush  in  1  branch mispredict flush from MEM
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NUM_SRC*REG_IDX_W  source register indices; source s is in bits [s*REG_IDX_W +: REG_IDX_W]
- id_rs_used  in  NUM_SRC  per-source "operand actually read" mask
- id_rd  in  REG_IDX_W  destination of the ID instruction
- id_wen  in  1  ID instruction writes the regfile
- id_lat  in  LAT_W  first slot index at which the result is forwardable (ALU 0, load 1)
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = regfile, k = result bus of slot k-1
- hazard_stall  out  1  hold IF/ID and issue a bubble into EX
- slot_valid  out  DEPTH  valid bit of each slot
- stall_cnt  out  32  cycles that lost an issue to hazard_stall
- flush_cnt  out  32  accepted flushes

## Operation
- Slot contents: valid, rd, lat. Slot i is ready when i >= lat. A lat value >= DEPTH is clamped to DEPTH-1.
- Match rule for source s: slot valid, rd != 0, rd == rs[s], and id_rs_used[s] set.
  - The youngest matching slot (lowest index) wins.
- Per-source outcome from the winning slot i:
  - ready: fwd_sel[s] = i+1.
  - not ready: source s raises the stall, and fwd_sel[s] = 0.
  - no match: fwd_sel[s] = 0.
- hazard_stall = any source not ready AND id_valid AND !flush.
- Advance (stall_n=1, rst=1):
  - slot[i] <= slot[i-1] for i >= 1.
  - slot0 <= {1, id_rd, id_lat} if id_valid && id_wen && !hazard_stall && !flush; otherwise a bubble (valid=0).
- Flush (flush=1 with stall_n=1): after the edge, slots 0..FLUSH_SLOTS-1 are invalid. Older slots shift normally.
  - With the default parameters, the branch in slot 1 moves to slot 2 and survives.
- stall_n=0: slots, counters and flush are ignored or held; outputs keep being recomputed from held state and current ID inputs.
- Counters:
  - stall_cnt increments on cycles with stall_n && hazard_stall.
  - flush_cnt increments on cycles with stall_n && flush.
  - Both saturate at 32'hFFFF_FFFF.

## Timing
- fwd_sel and hazard_stall are combinational from slot state and ID inputs, with zero-cycle latency. They are used in the same cycle as the EX operand muxes and the IF/ID hold.
- Load-use case (lat=1, consumer directly behind):
  - exactly one stall cycle;
  - on the next advance the producer is in slot 1, and fwd_sel = 2.
- Simultaneous flush and hazard: flush wins. No stall is asserted and slot 0 receives a bubble.
- Reset (rst=0 at the edge, regardless of stall_n):
  - all slots invalid, counters 0;
  - hence fwd_sel = 0, hazard_stall = 0, slot_valid = 0.
  - Reset mid-operation discards all in-flight entries.
- A writer leaving slot DEPTH-1 is dropped. The regfile write-through covers later reads.

## Test plan
- ALU chain: issue rd=x5 with lat=0, then ID has rs1=x5 -> next cycle fwd_sel[0]=1, hazard_stall=0; one cycle later (if still read) fwd_sel[0]=2.
- Load-use: issue rd=x6 with lat=1, then ID has rs2=x6 -> hazard_stall=1 for one cycle, stall_cnt=1, slot_valid=3'b010; next cycle fwd_sel[1]=2, hazard_stall=0.
- Youngest priority: x7 written by two consecutive ALU ops -> reader gets fwd_sel=1, not 2.
- Filtering: rs=x0 or id_rs_used=0 with a valid x0/xN writer in flight -> fwd_sel=0, no stall.
- Flush: slots 3'b011 plus a load-use stall pending, assert flush -> hazard_stall=0; after the edge slot_valid=3'b100, flush_cnt=1.
- Freeze and reset:
  - stall_n=0 for 5 cycles -> slot_valid and counters unchanged.
  - rst=0 for one edge while stall_n=0 -> all outputs 0.
